timebase_gen: RTL and testbench
===============================

// Module: timebase_gen
// PURPOSE
//   Parametrised timebase for the digital clock. Replaces chained divide-by-10 derived clocks
//   with one clock domain and single-cycle clock-enable ticks.
//   Produces a fast tick for display scanning, a slow (1 Hz) tick for the time counters,
//   a 50% blink signal for setting mode, and the sub-second phase.
//   Also provides prescaler resync and a fast-forward mode for time setting.
// PARAMETERS
//   CLK_HZ   50_000_000  input clock frequency, Hz
//   FAST_HZ  500         fast tick rate, Hz; CLK_HZ % FAST_HZ == 0
//   TICK_HZ  1           slow tick rate, Hz; FAST_HZ % (2*TICK_HZ) == 0
//   Derived: FAST_DIV = CLK_HZ/FAST_HZ; SLOW_RATIO = FAST_HZ/TICK_HZ
//            PRE_W = $clog2(FAST_DIV); SUB_W = $clog2(SLOW_RATIO)
//   Invalid ratios (FAST_DIV < 2, SLOW_RATIO odd or < 2) fail elaboration via generate-time $error.
// PORTS
//   clock_50MHZ  in   1      system clock; every register is clocked on its rising edge
//   reset        in   1      synchronous, active-high reset
//   enable       in   1      count enable; low = freeze
//   sync         in   1      synchronous prescaler clear (e.g. on set-time commit)
//   fast_fwd     in   1      1 = tick_slow follows every tick_fast (fast setting)
//   tick_fast    out  1      1-cycle pulse at FAST_HZ
//   tick_slow    out  1      1-cycle pulse at TICK_HZ (or FAST_HZ when fast_fwd = 1)
//   blink        out  1      square wave at TICK_HZ, 50% duty
//   phase        out  SUB_W  sub_cnt, i.e. fast ticks elapsed in current slow period
// BEHAVIOUR
//   State: pre_cnt[PRE_W-1:0] 0..FAST_DIV-1; sub_cnt[SUB_W-1:0] 0..SLOW_RATIO-1.
//   All outputs are registered.
//   Priority, per cycle: reset > sync > enable.
//   reset=1: pre_cnt=0, sub_cnt=0, tick_fast=0, tick_slow=0, blink=1, phase=0 next edge.
//   sync=1 (reset=0): same clear as reset, regardless of enable.
//     A pending terminal count is discarded, so no tick is emitted.
//   enable=0: counters and blink hold; tick_fast and tick_slow are 0 next cycle.
//   enable=1:
//     pre_cnt increments and wraps FAST_DIV-1 -> 0.
//     When pre_cnt == FAST_DIV-1, tick_fast = 1 for the next cycle and sub_cnt advances.
//     sub_cnt wraps SLOW_RATIO-1 -> 0. On that wrap, tick_slow = 1 for the next cycle.
//     fast_fwd=1: tick_slow = 1 on every cycle where tick_fast = 1; sub_cnt still counts normally.
//     fast_fwd is sampled in the same cycle as the pre_cnt terminal count.
//   blink register = (next sub_cnt < SLOW_RATIO/2).
//     It is 1 for the first half of each slow period and 0 for the second half.
//   phase equals the sub_cnt register.
//   Latency: with enable=1 held from the first cycle after reset,
//     tick_fast is high in cycles k*FAST_DIV (k >= 1), and
//     tick_slow is high in cycles k*FAST_DIV*SLOW_RATIO.
//     Cycle 0 is the first cycle with reset low.
//   tick_fast and tick_slow are never high for 2 consecutive cycles (FAST_DIV >= 2).
//   A tick_slow pulse always coincides with a tick_fast pulse.
//   Reset or sync mid-period: the next period restarts at full length; no runt tick.
//   Enable toggling mid-period only stretches the period; the tick count is preserved.
//   No derived clocks: outputs are clock enables only.
// TESTING (sim params CLK_HZ=100, FAST_HZ=10, TICK_HZ=1 -> FAST_DIV=10, SLOW_RATIO=10)
//   1. Reset 3 cycles, then enable=1 for 250 cycles
//      -> tick_fast at cycles 10,20,..,250; tick_slow at 100,200 only.
//      blink=1 in cycles 0..49, 0 in cycles 50..99, then repeats.
//   2. enable=0 for cycles 35..64, otherwise 1
//      -> tick_fast at 10,20,30,70,80; tick_slow first at 130; outputs held while frozen.
//   3. sync=1 at cycle 47
//      -> pre_cnt, phase and blink restart; next tick_fast at 58; tick_slow at 148.
//   4. fast_fwd=1 from cycle 0 -> tick_slow == tick_fast every cycle; phase still wraps 9->0.
//   5. reset=1 at cycle 99 (terminal count pending)
//      -> no tick in cycle 100; all outputs at reset values.
//   6. Elaborate with FAST_HZ=15, TICK_HZ=1 (odd SLOW_RATIO) -> elaboration error.

Source files
------------

// File: rtl/timebase_gen.sv
// Single-domain timebase for the digital clock: fast scan tick, 1 Hz tick,
// 50% blink and sub-second phase, all as registered clock-enable pulses.
//
// Ports:
//   clock_50MHZ  in   1      system clock, all registers on rising edge
//   reset        in   1      synchronous active-high reset
//   enable       in   1      count enable, low freezes counters and blink
//   sync         in   1      synchronous prescaler clear
//   fast_fwd     in   1      tick_slow follows every tick_fast
//   tick_fast    out  1      one-cycle pulse at FAST_HZ
//   tick_slow    out  1      one-cycle pulse at TICK_HZ (FAST_HZ in fast_fwd)
//   blink        out  1      TICK_HZ square wave, 50% duty
//   phase        out  SUB_W  fast ticks elapsed in the current slow period
module timebase_gen #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned FAST_HZ = 500,
    parameter int unsigned TICK_HZ = 1,
    localparam int unsigned FAST_DIV   = CLK_HZ / FAST_HZ,
    localparam int unsigned SLOW_RATIO = FAST_HZ / TICK_HZ,
    localparam int unsigned PRE_W = (FAST_DIV > 2) ? $clog2(FAST_DIV) : 1,
    localparam int unsigned SUB_W = (SLOW_RATIO > 2) ? $clog2(SLOW_RATIO) : 1
) (
    input  logic             clock_50MHZ,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync,
    input  logic             fast_fwd,
    output logic             tick_fast,
    output logic             tick_slow,
    output logic             blink,
    output logic [SUB_W-1:0] phase
);

    // Reject ratios that would give runt or asymmetric periods.
    if (FAST_DIV < 2 || (CLK_HZ % FAST_HZ) != 0) begin : g_bad_fast
        $error("timebase_gen: CLK_HZ/FAST_HZ must be an integer >= 2");
    end
    if (SLOW_RATIO < 2 || (SLOW_RATIO % 2) != 0 ||
        (FAST_HZ % TICK_HZ) != 0) begin : g_bad_slow
        $error("timebase_gen: FAST_HZ/TICK_HZ must be an even integer >= 2");
    end

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(FAST_DIV - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SLOW_RATIO - 1);
    localparam logic [SUB_W-1:0] SUB_HALF = SUB_W'(SLOW_RATIO / 2);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic             tick_fast_q, tick_fast_d;
    logic             tick_slow_q, tick_slow_d;
    logic             blink_q, blink_d;
    logic             pre_term, sub_term;

    assign pre_term = (pre_q == PRE_LAST);
    assign sub_term = (sub_q == SUB_LAST);

    always_comb begin
        pre_d       = pre_q;
        sub_d       = sub_q;
        blink_d     = blink_q;
        tick_fast_d = 1'b0;
        tick_slow_d = 1'b0;
        if (sync) begin
            // Drops any pending terminal count, so the next period is full length.
            pre_d   = '0;
            sub_d   = '0;
            blink_d = 1'b1;
        end else if (enable) begin
            pre_d = pre_term ? '0 : pre_q + PRE_W'(1);
            if (pre_term) begin
                sub_d       = sub_term ? '0 : sub_q + SUB_W'(1);
                tick_fast_d = 1'b1;
                tick_slow_d = sub_term | fast_fwd;
            end
            blink_d = (sub_d < SUB_HALF);
        end
    end

    always_ff @(posedge clock_50MHZ) begin
        if (reset) begin
            pre_q       <= '0;
            sub_q       <= '0;
            tick_fast_q <= 1'b0;
            tick_slow_q <= 1'b0;
            blink_q     <= 1'b1;
        end else begin
            pre_q       <= pre_d;
            sub_q       <= sub_d;
            tick_fast_q <= tick_fast_d;
            tick_slow_q <= tick_slow_d;
            blink_q     <= blink_d;
        end
    end

    assign tick_fast = tick_fast_q;
    assign tick_slow = tick_slow_q;
    assign blink     = blink_q;
    assign phase     = sub_q;

endmodule

// File: tb/tb_timebase_gen.sv
// Self-checking bench for timebase_gen with a tick-counting reference model.
// Sim parameters: FAST_DIV = 10, SLOW_RATIO = 10.
module tb_timebase_gen;

    localparam int FD = 10;
    localparam int SR = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       sync = 1'b0;
    logic       fast_fwd = 1'b0;
    logic       tick_fast, tick_slow, blink;
    logic [3:0] phase;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: count enabled cycles since the last clear.
    int         en_cnt = 0;
    logic       m_tf = 1'b0, m_ts = 1'b0, m_bl = 1'b1;
    logic [3:0] m_ph = '0;

    timebase_gen #(.CLK_HZ(100), .FAST_HZ(10), .TICK_HZ(1)) dut (
        .clock_50MHZ(clk),
        .reset(reset),
        .enable(enable),
        .sync(sync),
        .fast_fwd(fast_fwd),
        .tick_fast(tick_fast),
        .tick_slow(tick_slow),
        .blink(blink),
        .phase(phase)
    );

    always #5 clk = ~clk;

    // Apply inputs for one cycle, clock it, advance the model, settle.
    task automatic step(input logic r, input logic s,
                        input logic e, input logic ff);
        int f;
        reset = r; sync = s; enable = e; fast_fwd = ff;
        @(posedge clk);
        if (r || s) begin
            en_cnt = 0;
            m_tf = 0; m_ts = 0; m_ph = 0; m_bl = 1;
        end else if (!e) begin
            m_tf = 0; m_ts = 0;
        end else begin
            en_cnt++;
            if (en_cnt % FD == 0) begin
                f    = en_cnt / FD;
                m_tf = 1;
                m_ts = (f % SR == 0) || ff;
                m_ph = 4'(f % SR);
                m_bl = (f % SR) < SR / 2;
            end else begin
                m_tf = 0; m_ts = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        repeat (3) step(1, 0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({tick_fast, tick_slow, blink, phase} !== 7'b0010000) begin
            miscompares++;
            $display("FAIL reset: got tf=%b ts=%b bl=%b ph=%0d want 0 0 1 0",
                     tick_fast, tick_slow, blink, phase);
        end
    endtask

    task automatic test_free_run();
        logic etf, ets, ebl;
        do_reset();
        for (int c = 1; c <= 250; c++) begin
            step(0, 0, 1, 0);
            etf = (c % 10 == 0);
            ets = (c == 100 || c == 200);
            ebl = (c % 100) < 50;
            vectors++;
            if ({tick_fast, tick_slow, blink} !== {etf, ets, ebl}) begin
                miscompares++;
                $display("FAIL free_run c=%0d got tf=%b ts=%b bl=%b want %b %b %b",
                         c, tick_fast, tick_slow, blink, etf, ets, ebl);
            end
            vectors++;
            if (phase !== m_ph) begin
                miscompares++;
                $display("FAIL free_run_phase c=%0d got %0d want %0d",
                         c, phase, m_ph);
            end
        end
    endtask

    task automatic test_freeze();
        logic etf, ets;
        do_reset();
        for (int c = 1; c <= 140; c++) begin
            step(0, 0, !((c - 1) >= 35 && (c - 1) <= 64), 0);
            etf = (c == 10 || c == 20 || c == 30 ||
                   (c >= 70 && c % 10 == 0));
            ets = (c == 130);
            vectors++;
            if ({tick_fast, tick_slow} !== {etf, ets}) begin
                miscompares++;
                $display("FAIL freeze_ticks c=%0d got tf=%b ts=%b want %b %b",
                         c, tick_fast, tick_slow, etf, ets);
            end
            vectors++;
            if ({blink, phase} !== {m_bl, m_ph}) begin
                miscompares++;
                $display("FAIL freeze_hold c=%0d got bl=%b ph=%0d want %b %0d",
                         c, blink, phase, m_bl, m_ph);
            end
        end
    endtask

    task automatic test_sync();
        logic etf, ets;
        do_reset();
        for (int c = 1; c <= 160; c++) begin
            step(0, (c - 1) == 47, 1, 0);
            etf = (c < 48 && c % 10 == 0) ||
                  (c >= 58 && (c - 58) % 10 == 0);
            ets = (c == 148);
            vectors++;
            if ({tick_fast, tick_slow, blink, phase} !==
                {etf, ets, m_bl, m_ph}) begin
                miscompares++;
                $display("FAIL sync c=%0d got tf=%b ts=%b bl=%b ph=%0d want %b %b %b %0d",
                         c, tick_fast, tick_slow, blink, phase,
                         etf, ets, m_bl, m_ph);
            end
        end
    endtask

    task automatic test_fast_fwd();
        do_reset();
        for (int c = 1; c <= 150; c++) begin
            step(0, 0, 1, 1);
            vectors++;
            if (tick_slow !== tick_fast ||
                {tick_fast, blink, phase} !== {m_tf, m_bl, m_ph}) begin
                miscompares++;
                $display("FAIL fast_fwd c=%0d got tf=%b ts=%b bl=%b ph=%0d want %b %b %b %0d",
                         c, tick_fast, tick_slow, blink, phase,
                         m_tf, m_tf, m_bl, m_ph);
            end
        end
    endtask

    task automatic test_reset_pending();
        do_reset();
        for (int c = 1; c <= 99; c++) step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        vectors++;
        if ({tick_fast, tick_slow, blink, phase} !== 7'b0010000) begin
            miscompares++;
            $display("FAIL reset_pending got tf=%b ts=%b bl=%b ph=%0d want 0 0 1 0",
                     tick_fast, tick_slow, blink, phase);
        end
    endtask

    task automatic test_random();
        logic ptf, pts;
        do_reset();
        ptf = 0; pts = 0;
        for (int c = 1; c <= 3000; c++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
            vectors++;
            if ({tick_fast, tick_slow, blink, phase} !==
                {m_tf, m_ts, m_bl, m_ph}) begin
                miscompares++;
                $display("FAIL random c=%0d got tf=%b ts=%b bl=%b ph=%0d want %b %b %b %0d",
                         c, tick_fast, tick_slow, blink, phase,
                         m_tf, m_ts, m_bl, m_ph);
            end
            vectors++;
            if ((tick_slow && !tick_fast) || (tick_fast && ptf) ||
                (tick_slow && pts)) begin
                miscompares++;
                $display("FAIL random_pulse c=%0d got tf=%b ts=%b prev %b %b",
                         c, tick_fast, tick_slow, ptf, pts);
            end
            ptf = tick_fast;
            pts = tick_slow;
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_freeze();
        test_sync();
        test_fast_fwd();
        test_reset_pending();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
